// File: rtl/snake_axil_ctrl_regs.sv
// AXI4-Lite register bank for the snake game core: CTRL, DIR FIFO, SPEED, STATUS.
// Ports: S_AXI_* slave channels in; game_run/restart/speed_div, dir_* FIFO head, score/over in.
module snake_axil_ctrl_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          DIR_FIFO_DEPTH     = 4,
  parameter logic [15:0] SPEED_RESET        = 16'h0032
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            game_run,
  output logic                            game_restart,
  output logic [15:0]                     game_speed_div,
  output logic [1:0]                      dir_data,
  output logic                            dir_valid,
  input  logic                            dir_ready,
  input  logic [15:0]                     game_score,
  input  logic                            game_over
);

  localparam int PW = $clog2(DIR_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DIR_FIFO_DEPTH);

  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        run_q, run_d;
  logic        restart_q, restart_d;
  logic [15:0] speed_q, speed_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]  mem_q [DIR_FIFO_DEPTH];
  logic [1:0]  mem_d [DIR_FIFO_DEPTH];

  logic        wr_acc, rd_acc;
  logic [1:0]  wsel, rsel;
  logic        empty, full;
  logic        push, pop, flush, dir_err;

  assign wsel  = S_AXI_AWADDR[3:2];
  assign rsel  = S_AXI_ARADDR[3:2];
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL);

  // Ready is registered, so the accept edge is the one that ends the ready cycle.
  assign wr_acc = wready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_acc = arready_q & S_AXI_ARVALID;

  assign dir_err = wr_acc & (wsel == 2'd1) & S_AXI_WSTRB[0] & full;
  assign push    = wr_acc & (wsel == 2'd1) & S_AXI_WSTRB[0] & ~full;
  assign flush   = wr_acc & (wsel == 2'd0) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
  assign pop     = ~empty & dir_ready;

  always_comb begin
    wready_d  = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~wready_q;
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    run_d     = run_q;
    restart_d = flush;
    speed_d   = speed_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_d     = mem_q;

    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
      bresp_d  = 2'b00;
    end
    if (wr_acc) begin
      bvalid_d = 1'b1;
      bresp_d  = dir_err ? 2'b10 : 2'b00;
      if (wsel == 2'd0 && S_AXI_WSTRB[0]) run_d = S_AXI_WDATA[0];
      if (wsel == 2'd2) begin
        if (S_AXI_WSTRB[0]) speed_d[7:0]  = S_AXI_WDATA[7:0];
        if (S_AXI_WSTRB[1]) speed_d[15:8] = S_AXI_WDATA[15:8];
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = S_AXI_WDATA[1:0];
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    // Restart flush overrides any same-cycle pop.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_acc) begin
      rvalid_d = 1'b1;
      unique case (rsel)
        2'd0:    rdata_d = {31'b0, run_q};
        2'd1:    rdata_d = 32'(count_q);
        2'd2:    rdata_d = {16'b0, speed_q};
        default: rdata_d = {13'b0, empty, full, game_over, game_score};
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      run_q     <= 1'b0;
      restart_q <= 1'b0;
      speed_q   <= SPEED_RESET;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DIR_FIFO_DEPTH; i++) mem_q[i] <= 2'b00;
    end else begin
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      run_q     <= run_d;
      restart_q <= restart_d;
      speed_q   <= speed_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign S_AXI_AWREADY  = wready_q;
  assign S_AXI_WREADY   = wready_q;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_ARREADY  = arready_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = 2'b00;
  assign game_run       = run_q;
  assign game_restart   = restart_q;
  assign game_speed_div = speed_q;
  assign dir_valid      = ~empty;
  assign dir_data       = mem_q[rd_ptr_q];

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2]};

endmodule
